ddr2_timing_monitor: RTL and testbench

Parametrised DDR2 pad-level timing and protocol monitor. It observes the command bus at the controller pads and tracks per-bank and global timers. It flags tRCD, tRP, tRAS, tRC, tRRD and tRFC violations, plus illegal bank-state commands, through registered report outputs, sticky flags and a violation counter. It sits in the testbench beside the DUT pads and supersedes the fixed 4-bank coarse checker; its outputs feed the scoreboard instead of halting simulation.

---
 rtl/ddr2_timing_monitor_if.sv | 20 ++
 rtl/ddr2_timing_monitor.sv | 181 ++++++++++++++++++
 tb/tb_ddr2_timing_monitor.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ddr2_timing_monitor_if.sv
// DDR2 command-pad bundle observed by the timing monitor.
// master drives the pads (controller side), slave only samples them.
interface ddr2_timing_monitor_if #(
   parameter int unsigned BA_W = 2
);
   logic            cke_pad;
   logic            csbar_pad;
   logic            rasbar_pad;
   logic            casbar_pad;
   logic            webar_pad;
   logic [BA_W-1:0] ba_pad;
   logic            a10_pad;

   modport master (
      output cke_pad, csbar_pad, rasbar_pad, casbar_pad, webar_pad, ba_pad, a10_pad
   );
   modport slave (
      input  cke_pad, csbar_pad, rasbar_pad, casbar_pad, webar_pad, ba_pad, a10_pad
   );
endinterface

// File: rtl/ddr2_timing_monitor.sv
// DDR2 pad-level timing/protocol monitor: per-bank and global distance timers,
// registered violation reports, sticky flags and a saturating violation counter.
module ddr2_timing_monitor #(
   parameter int unsigned NUM_BANKS = 4,
   parameter int unsigned BA_W      = 2,
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned TRCD_MIN  = 4,
   parameter int unsigned TRP_MIN   = 4,
   parameter int unsigned TRAS_MIN  = 8,
   parameter int unsigned TRC_MIN   = 12,
   parameter int unsigned TRRD_MIN  = 2,
   parameter int unsigned TRFC_MIN  = 16,
   parameter int unsigned FATAL_EN  = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   ddr2_timing_monitor_if.slave   cmd,
   input  logic                   check_en,
   input  logic                   clear_flags,
   output logic                   viol_valid,
   output logic [2:0]             viol_code,
   output logic [BA_W-1:0]        viol_bank,
   output logic [6:0]             viol_flags,
   output logic [15:0]            viol_count,
   output logic [NUM_BANKS-1:0]   bank_open
);

   localparam logic [CNT_W-1:0] T_RCD = CNT_W'(TRCD_MIN);
   localparam logic [CNT_W-1:0] T_RP  = CNT_W'(TRP_MIN);
   localparam logic [CNT_W-1:0] T_RAS = CNT_W'(TRAS_MIN);
   localparam logic [CNT_W-1:0] T_RC  = CNT_W'(TRC_MIN);
   localparam logic [CNT_W-1:0] T_RRD = CNT_W'(TRRD_MIN);
   localparam logic [CNT_W-1:0] T_RFC = CNT_W'(TRFC_MIN);

   typedef enum logic [2:0] {
      CMD_NOP,
      CMD_ACT,
      CMD_PRE,
      CMD_REF,
      CMD_RD,
      CMD_WR
   } cmd_t;

   cmd_t             cmd_dec;
   logic [CNT_W-1:0] since_act [NUM_BANKS];
   logic [CNT_W-1:0] since_pre [NUM_BANKS];
   logic [CNT_W-1:0] since_any_act;
   logic [CNT_W-1:0] since_ref;
   logic [6:0]       viol;
   logic [2:0]       vcode;
   logic [BA_W-1:0]  vbank;
   logic             report;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] t);
      return (t == '1) ? t : t + CNT_W'(1);
   endfunction

   always_comb begin
      cmd_dec = CMD_NOP;
      if (cmd.cke_pad && !cmd.csbar_pad) begin
         case ({cmd.rasbar_pad, cmd.casbar_pad, cmd.webar_pad})
            3'b011:  cmd_dec = CMD_ACT;
            3'b010:  cmd_dec = CMD_PRE;
            3'b001:  cmd_dec = CMD_REF;
            3'b101:  cmd_dec = CMD_RD;
            3'b100:  cmd_dec = CMD_WR;
            default: cmd_dec = CMD_NOP;
         endcase
      end
   end

   // Bank searches run from the top down so the last hit is the lowest bank.
   always_comb begin
      viol  = '0;
      vbank = cmd.ba_pad;
      case (cmd_dec)
         CMD_ACT: begin
            viol[1] = since_pre[cmd.ba_pad] < T_RP;
            viol[3] = since_act[cmd.ba_pad] < T_RC;
            viol[4] = since_any_act < T_RRD;
            viol[5] = since_ref < T_RFC;
            viol[6] = bank_open[cmd.ba_pad];
         end
         CMD_RD, CMD_WR: begin
            viol[0] = since_act[cmd.ba_pad] < T_RCD;
            viol[6] = !bank_open[cmd.ba_pad];
         end
         CMD_PRE: begin
            if (!cmd.a10_pad) begin
               viol[2] = bank_open[cmd.ba_pad] && (since_act[cmd.ba_pad] < T_RAS);
            end else begin
               for (int unsigned i = NUM_BANKS; i > 0; i--) begin
                  if (bank_open[i-1] && (since_act[i-1] < T_RAS)) begin
                     viol[2] = 1'b1;
                     vbank   = BA_W'(i-1);
                  end
               end
            end
         end
         CMD_REF: begin
            viol[5] = since_ref < T_RFC;
            for (int unsigned i = NUM_BANKS; i > 0; i--) begin
               if (bank_open[i-1]) begin
                  viol[6] = 1'b1;
                  if (!viol[5]) vbank = BA_W'(i-1);
               end
            end
         end
         default: ;
      endcase

      vcode = '0;
      for (int unsigned k = 7; k > 0; k--) begin
         if (viol[k-1]) vcode = 3'(k);
      end
   end

   assign report = check_en && (viol != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            since_act[i] <= '1;
            since_pre[i] <= '1;
         end
         since_any_act <= '1;
         since_ref     <= '1;
         bank_open     <= '0;
         viol_valid    <= 1'b0;
         viol_code     <= '0;
         viol_bank     <= '0;
         viol_flags    <= '0;
         viol_count    <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            since_act[i] <= sat_inc(since_act[i]);
            since_pre[i] <= sat_inc(since_pre[i]);
         end
         since_any_act <= sat_inc(since_any_act);
         since_ref     <= sat_inc(since_ref);

         case (cmd_dec)
            CMD_ACT: begin
               since_act[cmd.ba_pad]  <= CNT_W'(1);
               since_any_act          <= CNT_W'(1);
               bank_open[cmd.ba_pad]  <= 1'b1;
            end
            CMD_PRE: begin
               if (cmd.a10_pad) begin
                  for (int unsigned i = 0; i < NUM_BANKS; i++) since_pre[i] <= CNT_W'(1);
                  bank_open <= '0;
               end else begin
                  since_pre[cmd.ba_pad] <= CNT_W'(1);
                  bank_open[cmd.ba_pad] <= 1'b0;
               end
            end
            CMD_REF: since_ref <= CNT_W'(1);
            default: ;
         endcase

         viol_valid <= report;
         if (report) begin
            viol_code  <= vcode;
            viol_bank  <= vbank;
            viol_flags <= (clear_flags ? 7'd0 : viol_flags) | viol;
            if (clear_flags)                viol_count <= 16'd1;
            else if (viol_count != 16'hFFFF) viol_count <= viol_count + 16'd1;
         end else if (clear_flags) begin
            viol_flags <= '0;
            viol_count <= '0;
         end
      end
   end

   if (FATAL_EN != 0) begin : g_fatal
      always_ff @(posedge clk) begin
         if (viol_valid) $fatal(1, "ddr2_timing_monitor violation code %0d bank %0d", viol_code, viol_bank);
      end
   end

endmodule

// File: tb/tb_ddr2_timing_monitor.sv
// Directed bench for ddr2_timing_monitor: one scenario per task, hand-computed expectations.
module tb_ddr2_timing_monitor;
   localparam logic [2:0] ACT = 3'b011;
   localparam logic [2:0] PRE = 3'b010;
   localparam logic [2:0] REF = 3'b001;
   localparam logic [2:0] RD  = 3'b101;
   localparam logic [2:0] WR  = 3'b100;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        check_en = 1'b1;
   logic        clear_flags = 1'b0;
   logic        viol_valid;
   logic [2:0]  viol_code;
   logic [1:0]  viol_bank;
   logic [6:0]  viol_flags;
   logic [15:0] viol_count;
   logic [3:0]  bank_open;
   int          checks = 0;
   int          failures = 0;

   ddr2_timing_monitor_if #(.BA_W(2)) bus();

   ddr2_timing_monitor #(
      .NUM_BANKS(4), .BA_W(2), .CNT_W(8), .TRCD_MIN(4), .TRP_MIN(4), .TRAS_MIN(8),
      .TRC_MIN(12), .TRRD_MIN(2), .TRFC_MIN(16), .FATAL_EN(0)
   ) dut (
      .clk(clk), .reset(reset), .cmd(bus.slave), .check_en(check_en),
      .clear_flags(clear_flags), .viol_valid(viol_valid), .viol_code(viol_code),
      .viol_bank(viol_bank), .viol_flags(viol_flags), .viol_count(viol_count),
      .bank_open(bank_open)
   );

   always #5 clk = ~clk;

   initial begin
      bus.cke_pad = 1'b1; bus.csbar_pad = 1'b1; bus.rasbar_pad = 1'b1;
      bus.casbar_pad = 1'b1; bus.webar_pad = 1'b1; bus.ba_pad = '0; bus.a10_pad = 1'b0;
   end

   // One command on the next rising edge; returns 1 time unit after that edge.
   task automatic issue(input logic [2:0] rcw, input logic [1:0] b, input logic a10);
      bus.csbar_pad = 1'b0;
      {bus.rasbar_pad, bus.casbar_pad, bus.webar_pad} = rcw;
      bus.ba_pad = b; bus.a10_pad = a10;
      @(posedge clk); #1;
      bus.csbar_pad = 1'b1; bus.a10_pad = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      reset = 1'b1; #2; reset = 1'b0;
   endtask

   task automatic test_reset;
      #1 reset = 1'b1; #1;
      checks++; if ({viol_valid, viol_code, viol_bank, viol_flags, viol_count, bank_open} !== 33'd0) begin
         failures++; $display("FAIL reset_outputs: got %h expected 0", {viol_valid, viol_code, viol_bank, viol_flags, viol_count, bank_open}); end
      reset = 1'b0;
   endtask

   task automatic test_trcd;
      apply_reset;
      issue(ACT, 2'd0, 1'b0);
      checks++; if (viol_valid !== 1'b0 || bank_open !== 4'b0001) begin
         failures++; $display("FAIL trcd_act: got valid=%b open=%b expected 0 0001", viol_valid, bank_open); end
      idle(2);
      issue(RD, 2'd0, 1'b0);
      checks++; if ({viol_valid, viol_code, viol_bank} !== {1'b1, 3'd1, 2'd0}) begin
         failures++; $display("FAIL trcd_report: got valid=%b code=%0d bank=%0d expected 1 1 0", viol_valid, viol_code, viol_bank); end
      checks++; if (viol_flags !== 7'b0000001 || viol_count !== 16'd1) begin
         failures++; $display("FAIL trcd_flags: got flags=%b count=%0d expected 0000001 1", viol_flags, viol_count); end
      idle(1);
      checks++; if (viol_valid !== 1'b0 || viol_code !== 3'd1) begin
         failures++; $display("FAIL trcd_hold: got valid=%b code=%0d expected 0 1", viol_valid, viol_code); end
      apply_reset;
      issue(ACT, 2'd1, 1'b0);
      idle(3);
      issue(WR, 2'd1, 1'b0);
      checks++; if (viol_valid !== 1'b0) begin
         failures++; $display("FAIL trcd_boundary: got valid=%b expected 0", viol_valid); end
   endtask

   task automatic test_trrd;
      apply_reset;
      issue(ACT, 2'd1, 1'b0);
      issue(ACT, 2'd2, 1'b0);
      checks++; if ({viol_valid, viol_code, viol_bank} !== {1'b1, 3'd5, 2'd2}) begin
         failures++; $display("FAIL trrd_report: got valid=%b code=%0d bank=%0d expected 1 5 2", viol_valid, viol_code, viol_bank); end
      apply_reset;
      issue(ACT, 2'd1, 1'b0);
      idle(1);
      issue(ACT, 2'd2, 1'b0);
      checks++; if (viol_valid !== 1'b0 || bank_open !== 4'b0110) begin
         failures++; $display("FAIL trrd_boundary: got valid=%b open=%b expected 0 0110", viol_valid, bank_open); end
   endtask

   task automatic test_trp_trc;
      apply_reset;
      issue(ACT, 2'd0, 1'b0);
      idle(7);
      issue(PRE, 2'd0, 1'b0);
      checks++; if (viol_valid !== 1'b0 || bank_open !== 4'b0000) begin
         failures++; $display("FAIL tras_boundary: got valid=%b open=%b expected 0 0000", viol_valid, bank_open); end
      idle(2);
      issue(ACT, 2'd0, 1'b0);
      checks++; if ({viol_valid, viol_code, viol_bank} !== {1'b1, 3'd2, 2'd0}) begin
         failures++; $display("FAIL trp_report: got valid=%b code=%0d bank=%0d expected 1 2 0", viol_valid, viol_code, viol_bank); end
      checks++; if (viol_flags !== 7'b0001010 || viol_count !== 16'd1) begin
         failures++; $display("FAIL trp_trc_flags: got flags=%b count=%0d expected 0001010 1", viol_flags, viol_count); end
   endtask

   task automatic test_tras_all;
      apply_reset;
      issue(ACT, 2'd0, 1'b0);
      idle(3);
      issue(ACT, 2'd3, 1'b0);
      checks++; if (viol_valid !== 1'b0 || bank_open !== 4'b1001) begin
         failures++; $display("FAIL tras_all_setup: got valid=%b open=%b expected 0 1001", viol_valid, bank_open); end
      idle(4);
      issue(PRE, 2'd0, 1'b1);
      checks++; if ({viol_valid, viol_code, viol_bank} !== {1'b1, 3'd3, 2'd3}) begin
         failures++; $display("FAIL tras_all_report: got valid=%b code=%0d bank=%0d expected 1 3 3", viol_valid, viol_code, viol_bank); end
      checks++; if (bank_open !== 4'b0000) begin
         failures++; $display("FAIL tras_all_open: got %b expected 0000", bank_open); end
   endtask

   task automatic test_ref_proto_clear;
      apply_reset;
      issue(REF, 2'd0, 1'b0);
      idle(9);
      issue(REF, 2'd0, 1'b0);
      checks++; if ({viol_valid, viol_code, viol_flags} !== {1'b1, 3'd6, 7'b0100000}) begin
         failures++; $display("FAIL trfc_report: got valid=%b code=%0d flags=%b expected 1 6 0100000", viol_valid, viol_code, viol_flags); end
      issue(RD, 2'd2, 1'b0);
      checks++; if ({viol_valid, viol_code, viol_bank} !== {1'b1, 3'd7, 2'd2}) begin
         failures++; $display("FAIL proto_rd_closed: got valid=%b code=%0d bank=%0d expected 1 7 2", viol_valid, viol_code, viol_bank); end
      checks++; if (viol_flags !== 7'b1100000 || viol_count !== 16'd2) begin
         failures++; $display("FAIL proto_flags: got flags=%b count=%0d expected 1100000 2", viol_flags, viol_count); end
      clear_flags = 1'b1; idle(1); clear_flags = 1'b0;
      checks++; if (viol_flags !== 7'd0 || viol_count !== 16'd0) begin
         failures++; $display("FAIL clear_flags: got flags=%b count=%0d expected 0 0", viol_flags, viol_count); end
      clear_flags = 1'b1;
      issue(RD, 2'd2, 1'b0);
      clear_flags = 1'b0;
      checks++; if (viol_flags !== 7'b1000000 || viol_count !== 16'd1) begin
         failures++; $display("FAIL clear_vs_report: got flags=%b count=%0d expected 1000000 1", viol_flags, viol_count); end
   endtask

   task automatic test_ref_open;
      apply_reset;
      issue(ACT, 2'd2, 1'b0);
      idle(1);
      issue(ACT, 2'd1, 1'b0);
      idle(1);
      issue(REF, 2'd3, 1'b0);
      checks++; if ({viol_valid, viol_code, viol_bank} !== {1'b1, 3'd7, 2'd1}) begin
         failures++; $display("FAIL ref_open_bank: got valid=%b code=%0d bank=%0d expected 1 7 1", viol_valid, viol_code, viol_bank); end
   endtask

   task automatic test_check_en;
      apply_reset;
      check_en = 1'b0;
      issue(RD, 2'd1, 1'b0);
      checks++; if ({viol_valid, viol_flags, viol_count} !== 24'd0) begin
         failures++; $display("FAIL check_en_off: got valid=%b flags=%b count=%0d expected 0 0 0", viol_valid, viol_flags, viol_count); end
      issue(ACT, 2'd0, 1'b0);
      check_en = 1'b1;
      idle(1);
      issue(RD, 2'd0, 1'b0);
      checks++; if ({viol_valid, viol_code, viol_count} !== {1'b1, 3'd1, 16'd1}) begin
         failures++; $display("FAIL check_en_timers: got valid=%b code=%0d count=%0d expected 1 1 1", viol_valid, viol_code, viol_count); end
   endtask

   task automatic test_async_reset;
      apply_reset;
      issue(ACT, 2'd0, 1'b0);
      idle(1);
      issue(ACT, 2'd2, 1'b0);
      issue(RD, 2'd1, 1'b0);
      checks++; if (bank_open !== 4'b0101 || viol_count !== 16'd1) begin
         failures++; $display("FAIL async_setup: got open=%b count=%0d expected 0101 1", bank_open, viol_count); end
      #2 reset = 1'b1; #1;
      checks++; if ({viol_valid, viol_code, viol_bank, viol_flags, viol_count, bank_open} !== 33'd0) begin
         failures++; $display("FAIL async_reset_outputs: got %h expected 0", {viol_valid, viol_code, viol_bank, viol_flags, viol_count, bank_open}); end
      #2 reset = 1'b0;
      issue(ACT, 2'd0, 1'b0);
      checks++; if (viol_valid !== 1'b0 || bank_open !== 4'b0001) begin
         failures++; $display("FAIL async_first_act: got valid=%b open=%b expected 0 0001", viol_valid, bank_open); end
   endtask

   initial begin
      test_reset;
      test_trcd;
      test_trrd;
      test_trp_trc;
      test_tras_all;
      test_ref_proto_clear;
      test_ref_open;
      test_check_en;
      test_async_reset;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
